// File: rtl/inst_cache_pkg.sv
// Shared constants, field widths and FSM encoding for the instruction cache.
package inst_cache_pkg;

  localparam int unsigned LINE_WORDS         = 4;
  localparam int unsigned INDEX_BITS_DEFAULT = 5;
  localparam int unsigned BYTE_BITS          = 2;  // byte-in-word address bits
  localparam int unsigned OFFSET_BITS        = 2;  // word-in-line address bits
  localparam int unsigned LINE_BYTE_BITS     = BYTE_BITS + OFFSET_BITS;

  // Tag is whatever remains of a 32-bit address above index and line offset.
  function automatic int unsigned tag_bits(input int unsigned index_bits);
    return 32 - LINE_BYTE_BITS - index_bits;
  endfunction

  localparam int unsigned TAG_BITS_DEFAULT = tag_bits(INDEX_BITS_DEFAULT);

  typedef logic [LINE_WORDS-1:0][31:0] line_t;

  typedef enum logic [0:0] {
    StIdle   = 1'b0,
    StRefill = 1'b1
  } state_e;

endpackage

// File: rtl/inst_cache_if.sv
// Fetch-side and memory-controller-side signals of the instruction cache.
interface inst_cache_if;

  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_handle;
  logic        inst_ready;
  logic [31:0] inst_out;
  logic        rob_clear;
  logic        mc_req;
  logic [31:0] mc_addr;
  logic        mc_valid;
  logic [31:0] mc_data;

  // Cache side.
  modport slave (
    input  inst_req, inst_addr, rob_clear, mc_valid, mc_data,
    output inst_handle, inst_ready, inst_out, mc_req, mc_addr
  );

  // Fetcher plus memory controller side.
  modport master (
    output inst_req, inst_addr, rob_clear, mc_valid, mc_data,
    input  inst_handle, inst_ready, inst_out, mc_req, mc_addr
  );

endinterface

// File: rtl/icache_array.sv
// Direct-mapped tag/valid/data storage: synchronous write, combinational read.
module icache_array import inst_cache_pkg::*; #(
  parameter int unsigned INDEX_BITS = INDEX_BITS_DEFAULT,
  parameter int unsigned TAG_BITS   = tag_bits(INDEX_BITS)
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  // read port
  input  logic [INDEX_BITS-1:0]  rd_index,
  output logic                   rd_valid,
  output logic [TAG_BITS-1:0]    rd_tag,
  output line_t                  rd_line,
  // word write port
  input  logic                   word_we,
  input  logic [INDEX_BITS-1:0]  wr_index,
  input  logic [OFFSET_BITS-1:0] wr_word,
  input  logic [31:0]            wr_data,
  // tag write also marks the line valid
  input  logic                   tag_we,
  input  logic [TAG_BITS-1:0]    wr_tag,
  // invalidate one line
  input  logic                   valid_clr,
  input  logic [INDEX_BITS-1:0]  clr_index
);

  localparam int unsigned LINES = 1 << INDEX_BITS;

  line_t               data_q [LINES];
  logic [TAG_BITS-1:0] tag_q  [LINES];
  logic [LINES-1:0]    valid_q;

  // Data and tag storage: no reset, contents are meaningless until valid.
  always_ff @(posedge clk_in) begin
    if (word_we) data_q[wr_index][wr_word] <= wr_data;
    if (tag_we)  tag_q[wr_index]           <= wr_tag;
  end

  // Valid bits: cleared on reset, on refill start, set on refill completion.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      valid_q <= '0;
    end else begin
      if (valid_clr) valid_q[clr_index] <= 1'b0;
      if (tag_we)    valid_q[wr_index]  <= 1'b1;
    end
  end

  assign rd_valid = valid_q[rd_index];
  assign rd_tag   = tag_q[rd_index];
  assign rd_line  = data_q[rd_index];

endmodule

// File: rtl/inst_cache.sv
// Direct-mapped instruction cache with 4-word line refill and flush cancellation.
module inst_cache import inst_cache_pkg::*; #(
  parameter int unsigned INDEX_BITS = INDEX_BITS_DEFAULT
) (
  input  logic         clk_in,
  input  logic         rst_in,
  input  logic         rdy_in,
  inst_cache_if.slave  bus
);

  localparam int unsigned TAG_BITS = tag_bits(INDEX_BITS);

  state_e                 state_q;
  logic [31:BYTE_BITS]    req_addr_q;  // word address of the miss being refilled
  logic [OFFSET_BITS-1:0] cnt_q;
  logic                   cancel_q;
  logic                   ready_q;
  logic [31:0]            out_q;
  logic                   mc_req_q;
  logic [31:0]            mc_addr_q;

  logic [INDEX_BITS-1:0]  idx_in, idx_req, rd_index;
  logic [TAG_BITS-1:0]    tag_in, tag_req, rd_tag;
  logic [OFFSET_BITS-1:0] off_in, off_req;
  logic                   rd_valid, hit, handle, refill_word, last_word;
  line_t                  rd_line;
  logic [31:0]            refill_out;
  logic                   unused_addr_bits;

  assign idx_in  = bus.inst_addr[LINE_BYTE_BITS +: INDEX_BITS];
  assign tag_in  = bus.inst_addr[31 -: TAG_BITS];
  assign off_in  = bus.inst_addr[BYTE_BITS +: OFFSET_BITS];
  assign idx_req = req_addr_q[LINE_BYTE_BITS +: INDEX_BITS];
  assign tag_req = req_addr_q[31 -: TAG_BITS];
  assign off_req = req_addr_q[BYTE_BITS +: OFFSET_BITS];
  assign unused_addr_bits = ^bus.inst_addr[BYTE_BITS-1:0];

  // In REFILL the read port watches the line being filled for the bypass.
  assign rd_index    = (state_q == StIdle) ? idx_in : idx_req;
  assign hit         = rd_valid && (rd_tag == tag_in);
  assign handle      = bus.inst_req && rdy_in && (state_q == StIdle);
  assign refill_word = (state_q == StRefill) && bus.mc_valid && rdy_in;
  assign last_word   = refill_word && (cnt_q == OFFSET_BITS'(LINE_WORDS - 1));

  // Requested word: already in the array unless it is the one arriving now.
  assign refill_out = (off_req == cnt_q) ? bus.mc_data : rd_line[off_req];

  icache_array #(
    .INDEX_BITS (INDEX_BITS),
    .TAG_BITS   (TAG_BITS)
  ) u_array (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .rd_index  (rd_index),
    .rd_valid  (rd_valid),
    .rd_tag    (rd_tag),
    .rd_line   (rd_line),
    .word_we   (refill_word),
    .wr_index  (idx_req),
    .wr_word   (cnt_q),
    .wr_data   (bus.mc_data),
    .tag_we    (last_word),
    .wr_tag    (tag_req),
    .valid_clr (handle && !hit),
    .clr_index (idx_in)
  );

  // Control FSM with registered response and refill-request outputs.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q    <= StIdle;
      req_addr_q <= '0;
      cnt_q      <= '0;
      cancel_q   <= 1'b0;
      ready_q    <= 1'b0;
      out_q      <= '0;
      mc_req_q   <= 1'b0;
      mc_addr_q  <= '0;
    end else if (rdy_in) begin
      ready_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (handle) begin
            if (hit) begin
              ready_q <= 1'b1;
              out_q   <= rd_line[off_in];
            end else begin
              req_addr_q <= bus.inst_addr[31:BYTE_BITS];
              mc_req_q   <= 1'b1;
              mc_addr_q  <= {bus.inst_addr[31:LINE_BYTE_BITS], LINE_BYTE_BITS'(0)};
              cnt_q      <= '0;
              cancel_q   <= 1'b0;
              state_q    <= StRefill;
            end
          end
        end
        StRefill: begin
          if (bus.rob_clear) cancel_q <= 1'b1;
          if (refill_word) begin
            cnt_q <= cnt_q + OFFSET_BITS'(1);
            if (last_word) begin
              mc_req_q <= 1'b0;
              cancel_q <= 1'b0;
              state_q  <= StIdle;
              // A flush on the final beat cancels just like an earlier one.
              if (!(cancel_q || bus.rob_clear)) begin
                ready_q <= 1'b1;
                out_q   <= refill_out;
              end
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.inst_handle = handle;
  // A flush kills any response visible in the same cycle.
  assign bus.inst_ready  = ready_q && !bus.rob_clear;
  assign bus.inst_out    = out_q;
  assign bus.mc_req      = mc_req_q;
  assign bus.mc_addr     = mc_addr_q;

endmodule

// File: tb/tb_inst_cache.sv
// Self-checking bench: directed scenarios plus random traffic against a line-level model.
module tb_inst_cache;

  logic clk;
  logic rst_n;
  logic rdy;

  inst_cache_if bus();

  inst_cache #(
    .INDEX_BITS (5)
  ) dut (
    .clk_in (clk),
    .rst_in (rst_n),
    .rdy_in (rdy),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Model: which memory line each cache slot holds, plus one outstanding miss.
  bit          m_line_ok [32];
  logic [27:0] m_line    [32];
  bit          m_busy;
  logic [31:0] m_addr;
  int          m_got;
  bit          m_cancel;
  bit          m_pend;
  logic [31:0] m_out;

  // Backing memory contents; line 0 holds 0x11..0x44.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] w;
    w = a & 32'hFFFF_FFFC;
    if (w[31:4] == 28'h0) return (32'(w[3:2]) + 32'd1) * 32'h11;
    return (w * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic void chk(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 32; i++) m_line_ok[i] = 1'b0;
    m_busy   = 1'b0;
    m_got    = 0;
    m_cancel = 1'b0;
    m_pend   = 1'b0;
    m_out    = '0;
  endfunction

  // One clock cycle: drive, compare at mid-cycle, advance model, end at posedge+1.
  task automatic step(input bit req, input logic [31:0] addr, input bit mcv,
                      input bit clr, input bit rd);
    bit np;
    int idx;
    bus.inst_req  = req;
    bus.inst_addr = addr;
    bus.rob_clear = clr;
    bus.mc_valid  = mcv;
    bus.mc_data   = (m_busy && mcv) ? mem_word((m_addr & ~32'hF) + 32'(4 * m_got))
                                    : $urandom;
    rdy = rd;
    #4;
    chk("inst_handle", 32'(bus.inst_handle), 32'(req && rd && !m_busy));
    chk("inst_ready", 32'(bus.inst_ready), 32'(m_pend && !clr));
    chk("inst_out", bus.inst_out, m_out);
    chk("mc_req", 32'(bus.mc_req), 32'(m_busy));
    if (m_busy) chk("mc_addr", bus.mc_addr, m_addr & ~32'hF);
    if (rd) begin
      np = 1'b0;
      if (!m_busy) begin
        if (req) begin
          idx = int'(addr[8:4]);
          if (m_line_ok[idx] && m_line[idx] == addr[31:4]) begin
            np    = 1'b1;
            m_out = mem_word(addr);
          end else begin
            m_busy         = 1'b1;
            m_addr         = addr;
            m_got          = 0;
            m_cancel       = 1'b0;
            m_line_ok[idx] = 1'b0;
          end
        end
      end else begin
        if (clr) m_cancel = 1'b1;
        if (mcv) begin
          m_got++;
          if (m_got == 4) begin
            idx            = int'(m_addr[8:4]);
            m_line_ok[idx] = 1'b1;
            m_line[idx]    = m_addr[31:4];
            m_busy         = 1'b0;
            if (!m_cancel) begin
              np    = 1'b1;
              m_out = mem_word(m_addr);
            end
          end
        end
      end
      m_pend = np;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
  endtask

  // Asynchronous reset pulse starting at posedge+1.
  task automatic do_reset();
    bus.inst_req = 1'b0;
    bus.mc_valid = 1'b0;
    bus.rob_clear = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_mc_req", 32'(bus.mc_req), 32'h0);
    chk("rst_inst_ready", 32'(bus.inst_ready), 32'h0);
    chk("rst_inst_out", bus.inst_out, 32'h0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n         = 1'b0;
    rdy           = 1'b1;
    bus.inst_req  = 1'b0;
    bus.inst_addr = '0;
    bus.rob_clear = 1'b0;
    bus.mc_valid  = 1'b0;
    bus.mc_data   = '0;
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("reset_mc_req", 32'(bus.mc_req), 32'h0);
    chk("reset_mc_addr", bus.mc_addr, 32'h0);
    chk("reset_inst_ready", 32'(bus.inst_ready), 32'h0);
    chk("reset_inst_out", bus.inst_out, 32'h0);
    rst_n = 1'b1;

    // Cold miss on line 0, refill 0x11..0x44.
    step(1'b1, 32'h0, 1'b0, 1'b0, 1'b1);
    chk("miss0_mc_req", 32'(bus.mc_req), 32'h1);
    chk("miss0_mc_addr", bus.mc_addr, 32'h0);
    feed(4);
    chk("refill0_ready", 32'(bus.inst_ready), 32'h1);
    chk("refill0_out", bus.inst_out, 32'h11);

    // Back-to-back hits on the rest of the line.
    step(1'b1, 32'h4, 1'b0, 1'b0, 1'b1);
    chk("hit4_out", bus.inst_out, 32'h22);
    step(1'b1, 32'h8, 1'b0, 1'b0, 1'b1);
    chk("hit8_ready", 32'(bus.inst_ready), 32'h1);
    chk("hit8_out", bus.inst_out, 32'h33);
    step(1'b1, 32'hC, 1'b0, 1'b0, 1'b1);
    chk("hitC_out", bus.inst_out, 32'h44);
    chk("hits_no_mc_req", 32'(bus.mc_req), 32'h0);
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);

    // Conflict miss on the same index, then eviction of line 0.
    step(1'b1, 32'h200, 1'b0, 1'b0, 1'b1);
    chk("miss200_mc_addr", bus.mc_addr, 32'h200);
    feed(4);
    chk("refill200_out", bus.inst_out, mem_word(32'h200));
    step(1'b1, 32'h0, 1'b0, 1'b0, 1'b1);
    chk("evict_mc_req", 32'(bus.mc_req), 32'h1);
    chk("evict_mc_addr", bus.mc_addr, 32'h0);
    feed(4);
    chk("refill0b_out", bus.inst_out, 32'h11);

    // Flush mid-refill: line installs, no response, later hit.
    step(1'b1, 32'h38, 1'b0, 1'b0, 1'b1);
    feed(2);
    step(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
    feed(2);
    chk("cancel_no_ready", 32'(bus.inst_ready), 32'h0);
    chk("cancel_mc_req_drop", 32'(bus.mc_req), 32'h0);
    step(1'b1, 32'h34, 1'b0, 1'b0, 1'b1);
    chk("after_cancel_hit", 32'(bus.inst_ready), 32'h1);
    chk("after_cancel_out", bus.inst_out, mem_word(32'h34));

    // Flush coincident with hit accept, then flush the cycle after a hit.
    step(1'b1, 32'h8, 1'b0, 1'b1, 1'b1);
    bus.rob_clear = 1'b0;
    bus.inst_req  = 1'b0;
    #1;
    chk("coinc_clear_ready", 32'(bus.inst_ready), 32'h1);
    chk("coinc_clear_out", bus.inst_out, 32'h33);
    step(1'b1, 32'hC, 1'b0, 1'b0, 1'b1);
    bus.rob_clear = 1'b1;
    bus.inst_req  = 1'b0;
    #1;
    chk("late_clear_ready", 32'(bus.inst_ready), 32'h0);
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);

    // Reset mid-refill abandons the line.
    step(1'b1, 32'h50, 1'b0, 1'b0, 1'b1);
    feed(2);
    do_reset();
    step(1'b1, 32'h50, 1'b0, 1'b0, 1'b1);
    chk("post_reset_miss", 32'(bus.mc_req), 32'h1);
    feed(4);
    chk("post_reset_out", bus.inst_out, mem_word(32'h50));

    // Random traffic over a few conflicting lines with stalls and flushes.
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] a;
      if ($urandom_range(0, 399) == 0) begin
        do_reset();
      end else begin
        a = (32'($urandom_range(0, 2)) << 9) | (32'($urandom_range(0, 3)) << 4) |
            (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
        step($urandom_range(0, 9) < 7, a, $urandom_range(0, 9) < 6,
             $urandom_range(0, 9) == 0, $urandom_range(0, 7) != 0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/inst_cache.md
INST_CACHE -- requirements
Module: inst_cache

Interface
REQ-001 Parameter INDEX_BITS, default 5, number of index bits (2^INDEX_BITS lines, direct-mapped).
REQ-002 Parameter LINE_WORDS, fixed 4: 32-bit words per line (16-byte line).
REQ-003 clk_in  input  1  system clock; all state updates on its rising edge.
REQ-004 rst_in  input  1  reset, asynchronous, active-low.
REQ-005 rdy_in  input  1  when low, all state holds and no handshake is accepted.
REQ-006 inst_req  input  1  fetcher requests the instruction at inst_addr.
REQ-007 inst_addr  input  32  byte address of the instruction; bits [1:0] ignored.
REQ-008 inst_handle  output  1  combinational; request accepted this cycle.
REQ-009 inst_ready  output  1  registered one-cycle pulse; inst_out is valid.
REQ-010 inst_out  output  32  instruction word for the last accepted request.
REQ-011 rob_clear  input  1  pipeline flush; cancels any outstanding response.
REQ-012 mc_req  output  1  line refill request to the memory controller.
REQ-013 mc_addr  output  32  line-aligned refill address (bits [3:0] zero).
REQ-014 mc_valid  input  1  one returned word is on mc_data this cycle.
REQ-015 mc_data  input  32  returned word, delivered in order word0..word3.

Function
REQ-016 Address split: offset = addr[3:2], index = addr[4+INDEX_BITS-1:4], tag = remaining upper bits.
REQ-017 States: IDLE, REFILL.
REQ-018 inst_handle SHALL equal inst_req AND rdy_in AND state==IDLE.
REQ-019 Accepted request, hit (valid and tag match): inst_ready=1 with the word on the next edge; state stays IDLE, so back-to-back hits run at one per cycle.
REQ-020 Accepted request, miss: latch the address, enter REFILL, and assert mc_req with mc_addr = {addr[31:4],4'b0}.
REQ-021 mc_req and mc_addr SHALL hold stable until the 4th mc_valid is seen.
REQ-022 REFILL: a 2-bit word counter starts at 0, and each mc_valid writes mc_data into data[index][counter], then increments.
REQ-023 On the 4th mc_valid: set the valid bit, write the tag, drop mc_req the next cycle, and return to IDLE.
REQ-024 Refill response: the cycle after the 4th mc_valid, inst_ready=1 and inst_out = the requested word (bypassed from the refilled line), unless cancelled.
REQ-025 rob_clear in REFILL: set the cancel flag; the refill SHALL still complete and install the line, but produce no inst_ready; the flag clears on return to IDLE.
REQ-026 rob_clear in the cycle after a hit accept: suppress that cycle's inst_ready (forced 0).
REQ-027 rob_clear and inst_handle in the same cycle: the new request is accepted normally; only older responses are cancelled.
REQ-028 inst_ready SHALL never be asserted while rob_clear is high.
REQ-029 mc_valid outside REFILL SHALL be ignored.
REQ-030 inst_out holds its last value when inst_ready is low.
REQ-031 rdy_in low: freeze the FSM, the counter and the arrays; an inst_ready pending for that edge is deferred to the first rdy_in-high edge.

Reset
REQ-032 rst_in low SHALL immediately: clear all valid bits, set state=IDLE, inst_ready=0, mc_req=0, mc_addr=0, inst_out=0, counter=0, cancel=0.
REQ-033 Reset mid-REFILL abandons the line; it stays invalid.
REQ-034 Data and tag arrays need no reset.

Structure
REQ-035 A shared package SHALL hold LINE_WORDS, the default INDEX_BITS, the offset/index/tag field widths, and the state encoding.
REQ-036 One sub-module, icache_array: a synchronous-write, combinational-read tag/valid/data storage with a word write-enable and a valid-clear input.

Verification
REQ-037 After reset, request 0x0000_0000 -> inst_handle=1, mc_req with mc_addr=0x0; feed words 0x11,0x22,0x33,0x44 -> inst_ready one cycle after the 4th word, inst_out=0x11.
REQ-038 Next, requests 0x4, 0x8, 0xC on consecutive cycles -> three consecutive inst_ready pulses with 0x22, 0x33, 0x44, and no mc_req.
REQ-039 Request 0x200 (same index as 0x0 for INDEX_BITS=5, different tag) -> miss and refill; then request 0x0 -> miss again (eviction).
REQ-040 rob_clear after the 2nd refill word -> no inst_ready; the refill completes; a later request to the same line hits with a 1-cycle response.
REQ-041 rob_clear coincident with a hit accept for 0x8 -> inst_ready next cycle with word 0x33; rob_clear the cycle after a hit -> inst_ready stays 0.
REQ-042 rst_in pulsed low mid-REFILL -> mc_req=0 immediately; a later request to that line misses.
